ps2_rx: RTL and testbench

Receive-only PS/2 host interface for the DE0-CV keyboard port, opposite end of the device-to-host link. It synchronizes and deglitches PS2_CLK/PS2_DAT and decodes 11-bit frames: start, 8 data bits LSB first, odd parity, stop. It checks each frame and queues good bytes in a small FIFO. The FIFO has a valid/ready output port that feeds the `core` key/scancode logic.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_rx_fifo.sv | 46 ++++
 rtl/ps2_rx.sv | 152 +++++++++++++++
 tb/tb_ps2_rx.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Holds the frame FSM states, the rejection codes and the timeout sizing helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_PARITY  = 2'd1;
    localparam logic [1:0] ERR_STOP    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    function automatic int unsigned timeout_cyc(input int unsigned clk_hz,
                                                 input int unsigned timeout_us);
        return (clk_hz / 1000000) * timeout_us;
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Small synchronous byte FIFO; an extra pointer bit tells full from empty.
// A push while full is only accepted when a pop frees the head slot that same cycle.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= din;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// Receive-only PS/2 host: synchronize and deglitch the pins, decode 11-bit frames,
// queue good bytes in a FIFO and flag parity, stop-bit and inter-edge timeout errors.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       m_clock,
    input  logic       p_reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_err,
    output logic [1:0] err_code,
    output logic       overflow
);

    localparam int unsigned TIMEOUT_CYC = timeout_cyc(CLK_HZ, TIMEOUT_US);
    localparam int          TW          = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]            r_clk_sync;
    logic [1:0]            r_dat_sync;
    logic [FILTER_LEN-1:0] r_filt;
    logic                  r_fclk;
    ps2_state_t            r_state;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_shreg;
    logic                  r_parity;
    logic                  r_push;
    logic                  r_err;
    logic [1:0]            r_err_code;
    logic [TW-1:0]         r_to_cnt;

    logic w_clk_s;
    logic w_dat_s;
    logic w_all_lo;
    logic w_all_hi;
    logic w_strobe;
    logic w_full;
    logic w_empty;
    logic w_pop;

    assign w_clk_s  = r_clk_sync[1];
    assign w_dat_s  = r_dat_sync[1];
    assign w_all_lo = (r_filt == '0);
    assign w_all_hi = &r_filt;
    assign w_strobe = r_fclk & w_all_lo;

    // Pins idle high, so the synchronizers and filter start out high too.
    always_ff @(posedge m_clock or negedge p_reset_n) begin
        if (!p_reset_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_filt     <= '1;
            r_fclk     <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_dat};
            r_filt     <= {r_filt[FILTER_LEN-2:0], w_clk_s};
            if (w_all_hi)      r_fclk <= 1'b1;
            else if (w_all_lo) r_fclk <= 1'b0;
        end
    end

    // A strobe always takes priority over timeout expiry in the same cycle.
    always_ff @(posedge m_clock or negedge p_reset_n) begin
        if (!p_reset_n) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_parity   <= 1'b0;
            r_push     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_to_cnt   <= '0;
        end else begin
            r_push <= 1'b0;
            r_err  <= 1'b0;
            if (w_strobe) begin
                r_to_cnt <= '0;
                case (r_state)
                    ST_IDLE: begin
                        if (!w_dat_s) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        r_shreg   <= {w_dat_s, r_shreg[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        r_parity <= w_dat_s;
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                        if (^{r_shreg, r_parity} == 1'b0) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_PARITY;
                        end else if (!w_dat_s) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_STOP;
                        end else begin
                            r_push <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (r_state != ST_IDLE) begin
                if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    r_err      <= 1'b1;
                    r_err_code <= ERR_TIMEOUT;
                    r_state    <= ST_IDLE;
                    r_to_cnt   <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // shreg stays put until the next frame's data bits, so it can feed the FIFO directly.
    ps2_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (8)
    ) u_fifo (
        .clk   (m_clock),
        .rst_n (p_reset_n),
        .push  (r_push),
        .din   (r_shreg),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (rx_data),
        .empty (w_empty)
    );

    assign w_pop    = rx_ready & ~w_empty;
    assign rx_valid = ~w_empty;
    assign rx_err   = r_err;
    assign err_code = r_err_code;
    assign overflow = r_push & w_full & ~w_pop;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: drives PS/2 frames on the pins and checks outputs against
// a frame-level model (odd parity, stop bit, byte queue of FIFO_DEPTH entries).
module tb_ps2_rx;

    localparam int CLK_HZ     = 1000000;
    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT_US = 2000;
    localparam int FIFO_DEPTH = 4;
    localparam int TC         = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int HP         = 30;
    localparam int LAT        = 2 + FILTER_LEN;

    logic       m_clock   = 1'b0;
    logic       p_reset_n = 1'b0;
    logic       ps2_clk   = 1'b1;
    logic       ps2_dat   = 1'b1;
    logic       rx_ready  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [1:0] err_code;
    logic       overflow;

    ps2_rx #(
        .CLK_HZ     (CLK_HZ),
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_US (TIMEOUT_US),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .m_clock   (m_clock),
        .p_reset_n (p_reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_err    (rx_err),
        .err_code  (err_code),
        .overflow  (overflow)
    );

    always #5 m_clock = ~m_clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_cnt = 0, ovf_cnt = 0, err_cyc = 0, ovf_cyc = 0, vrise_cyc = 0;
    logic prev_v = 1'b0;

    always @(posedge m_clock) cyc <= cyc + 1;

    always @(negedge m_clock) begin
        prev_v <= rx_valid;
        if (rx_valid && !prev_v) vrise_cyc <= cyc;
        if (rx_err)   begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
        if (overflow) begin ovf_cnt <= ovf_cnt + 1; ovf_cyc <= cyc; end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Reference model state
    logic [7:0] q[$];
    logic [1:0] m_code = 2'd0;
    int         exp_err = 0, exp_ovf = 0;
    int         fall_cyc = 0;

    function automatic logic odd_par(input logic [7:0] d);
        return ($countones(d) % 2 == 0);
    endfunction

    task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
        if ($countones({d, par}) % 2 == 0) begin m_code = 2'd1; exp_err++; end
        else if (!stop)                     begin m_code = 2'd2; exp_err++; end
        else if (q.size() < FIFO_DEPTH)     q.push_back(d);
        else                                exp_ovf++;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge m_clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int nbits, input bit glitch, input bit pop_at_push);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            if (glitch) begin
                wait_cyc(4); ps2_clk = 1'b0; wait_cyc(4); ps2_clk = 1'b1; wait_cyc(HP/2 - 8);
            end else begin
                wait_cyc(HP/2);
            end
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            if (pop_at_push && i == 10) begin
                wait_cyc(LAT + 1); rx_ready = 1'b1; wait_cyc(1); rx_ready = 1'b0;
                wait_cyc(HP - LAT - 2);
            end else begin
                wait_cyc(HP);
            end
            ps2_clk = 1'b1;
            wait_cyc(HP/2);
        end
        ps2_dat = 1'b1;
    endtask

    task automatic pop_one(output logic [7:0] got, output bit ok);
        int n;
        n = 0;
        @(negedge m_clock);
        while (!rx_valid && n < 2000) begin @(negedge m_clock); n++; end
        ok  = rx_valid;
        got = rx_data;
        if (ok) begin
            rx_ready = 1'b1;
            @(negedge m_clock);
            rx_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        wait_cyc(3);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", rx_err); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", err_code); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        p_reset_n = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_single;
        int e0; logic [7:0] got, exp; bit ok;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
        model_frame(8'h1C, 1'b0, 1'b1);
        wait_cyc(5);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", rx_valid); end
        checks++; if (rx_data !== 8'h1C) begin errors++; $display("FAIL single_data: got %h expected 1c", rx_data); end
        checks++; if (vrise_cyc != fall_cyc + LAT + 2) begin errors++; $display("FAIL single_latency: got %0d expected %0d", vrise_cyc - fall_cyc, LAT + 2); end
        checks++; if (err_cnt != e0) begin errors++; $display("FAIL single_no_err: got %0d pulses expected 0", err_cnt - e0); end
        pop_one(got, ok);
        exp = q.pop_front();
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL single_pop: got %h (valid %b) expected %h", got, ok, exp); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_empty: got %b expected 0", rx_valid); end
    endtask

    task automatic test_order;
        logic [7:0] got, exp; bit ok;
        send_frame(8'hF0, odd_par(8'hF0), 1'b1, 11, 1'b0, 1'b0);
        model_frame(8'hF0, odd_par(8'hF0), 1'b1);
        send_frame(8'h1C, odd_par(8'h1C), 1'b1, 11, 1'b0, 1'b0);
        model_frame(8'h1C, odd_par(8'h1C), 1'b1);
        wait_cyc(5);
        for (int i = 0; i < 2; i++) begin
            pop_one(got, ok);
            exp = q.pop_front();
            checks++; if (!ok || got !== exp) begin errors++; $display("FAIL order_pop%0d: got %h (valid %b) expected %h", i, got, ok, exp); end
        end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL order_empty: got %b expected 0", rx_valid); end
    endtask

    task automatic test_errors;
        int e0;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
        model_frame(8'h1C, 1'b1, 1'b1);
        wait_cyc(5);
        checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL parity_pulses: got %0d expected 1", err_cnt - e0); end
        checks++; if (err_code !== m_code) begin errors++; $display("FAIL parity_code: got %0d expected %0d", err_code, m_code); end
        checks++; if (err_cyc != fall_cyc + LAT + 1) begin errors++; $display("FAIL parity_latency: got %0d expected %0d", err_cyc - fall_cyc, LAT + 1); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL parity_fifo: got %b expected 0", rx_valid); end
        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0, 1'b0);
        model_frame(8'h1C, 1'b0, 1'b0);
        wait_cyc(5);
        checks++; if (err_code !== m_code) begin errors++; $display("FAIL stop_code: got %0d expected %0d", err_code, m_code); end
        checks++; if (err_cnt - e0 != 2) begin errors++; $display("FAIL stop_pulses: got %0d expected 2", err_cnt - e0); end
    endtask

    task automatic test_timeout;
        int e0, n, d; logic [7:0] got, exp; bit ok;
        e0 = err_cnt;
        send_frame(8'h05, 1'b0, 1'b1, 4, 1'b0, 1'b0);
        n = 0;
        while (err_cnt == e0 && n < TC + 200) begin wait_cyc(1); n++; end
        wait_cyc(2);
        m_code = 2'd3;
        checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL timeout_pulses: got %0d expected 1", err_cnt - e0); end
        checks++; if (err_code !== m_code) begin errors++; $display("FAIL timeout_code: got %0d expected 3", err_code); end
        d = err_cyc - (fall_cyc + LAT + 1 + TC);
        checks++; if (d < -1 || d > 1) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", err_cyc - fall_cyc, LAT + 1 + TC); end
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, 11, 1'b0, 1'b0);
        model_frame(8'h5A, odd_par(8'h5A), 1'b1);
        pop_one(got, ok);
        exp = q.pop_front();
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL timeout_next: got %h (valid %b) expected %h", got, ok, exp); end
    endtask

    task automatic test_overflow;
        int o0; logic [7:0] got, exp, b; bit ok;
        o0 = ovf_cnt;
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            send_frame(b, odd_par(b), 1'b1, 11, 1'b0, 1'b0);
            model_frame(b, odd_par(b), 1'b1);
        end
        wait_cyc(5);
        checks++; if (ovf_cnt - o0 != exp_ovf) begin errors++; $display("FAIL ovf_pulses: got %0d expected %0d", ovf_cnt - o0, exp_ovf); end
        checks++; if (ovf_cyc != fall_cyc + LAT + 1) begin errors++; $display("FAIL ovf_latency: got %0d expected %0d", ovf_cyc - fall_cyc, LAT + 1); end
        // byte 6 arrives while the consumer pops the head in the same cycle
        send_frame(8'h06, odd_par(8'h06), 1'b1, 11, 1'b0, 1'b1);
        void'(q.pop_front());
        q.push_back(8'h06);
        wait_cyc(5);
        checks++; if (ovf_cnt - o0 != exp_ovf) begin errors++; $display("FAIL ovf_pushpop: got %0d expected %0d", ovf_cnt - o0, exp_ovf); end
        while (q.size() > 0) begin
            pop_one(got, ok);
            exp = q.pop_front();
            checks++; if (!ok || got !== exp) begin errors++; $display("FAIL ovf_drain: got %h (valid %b) expected %h", got, ok, exp); end
        end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b expected 0", rx_valid); end
        exp_ovf = 0;
    endtask

    task automatic test_glitch;
        int e0; logic [7:0] got, exp; bit ok;
        e0 = err_cnt;
        send_frame(8'h1C, odd_par(8'h1C), 1'b1, 11, 1'b1, 1'b0);
        model_frame(8'h1C, odd_par(8'h1C), 1'b1);
        pop_one(got, ok);
        exp = q.pop_front();
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL glitch_data: got %h (valid %b) expected %h", got, ok, exp); end
        checks++; if (err_cnt != e0) begin errors++; $display("FAIL glitch_err: got %0d pulses expected 0", err_cnt - e0); end
    endtask

    task automatic test_random;
        int e0, o0, x0; logic [7:0] d, got, exp; logic par, stop; bit ok;
        e0 = err_cnt; o0 = ovf_cnt; x0 = exp_err;
        for (int i = 0; i < 6; i++) begin
            d    = 8'($urandom);
            par  = ($urandom_range(0, 3) == 0) ? ~odd_par(d) : odd_par(d);
            stop = ($urandom_range(0, 6) != 0);
            send_frame(d, par, stop, 11, 1'b0, 1'b0);
            model_frame(d, par, stop);
            wait_cyc(5);
            checks++; if (err_code !== m_code) begin errors++; $display("FAIL rand_code%0d: got %0d expected %0d", i, err_code, m_code); end
            wait_cyc($urandom_range(5, 50));
        end
        checks++; if (err_cnt - e0 != exp_err - x0) begin errors++; $display("FAIL rand_errs: got %0d expected %0d", err_cnt - e0, exp_err - x0); end
        checks++; if (ovf_cnt - o0 != exp_ovf) begin errors++; $display("FAIL rand_ovf: got %0d expected %0d", ovf_cnt - o0, exp_ovf); end
        while (q.size() > 0) begin
            pop_one(got, ok);
            exp = q.pop_front();
            checks++; if (!ok || got !== exp) begin errors++; $display("FAIL rand_drain: got %h (valid %b) expected %h", got, ok, exp); end
        end
        exp_ovf = 0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] got, exp; bit ok;
        send_frame(8'h1C, ~odd_par(8'h1C), 1'b1, 11, 1'b0, 1'b0);
        model_frame(8'h1C, ~odd_par(8'h1C), 1'b1);
        send_frame(8'h33, odd_par(8'h33), 1'b1, 11, 1'b0, 1'b0);
        model_frame(8'h33, odd_par(8'h33), 1'b1);
        send_frame(8'hA5, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        ps2_clk = 1'b0;
        wait_cyc(3);
        p_reset_n = 1'b0;
        #1;
        q.delete(); m_code = 2'd0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", rx_data); end
        checks++; if (err_code !== m_code) begin errors++; $display("FAIL rstmid_code: got %0d expected 0", err_code); end
        checks++; if (rx_err !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rstmid_pulses: got err %b ovf %b expected 0 0", rx_err, overflow); end
        ps2_clk = 1'b1; ps2_dat = 1'b1;
        wait_cyc(4);
        p_reset_n = 1'b1;
        wait_cyc(20);
        send_frame(8'h1C, odd_par(8'h1C), 1'b1, 11, 1'b0, 1'b0);
        model_frame(8'h1C, odd_par(8'h1C), 1'b1);
        pop_one(got, ok);
        exp = q.pop_front();
        checks++; if (!ok || got !== exp) begin errors++; $display("FAIL rstmid_after: got %h (valid %b) expected %h", got, ok, exp); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_errors();
        test_timeout();
        test_overflow();
        test_glitch();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
